aes_inv_key_sched: RTL and testbench

Inverse-cipher round-key scheduler for the AES-128 decryption path. It accepts a 128-bit cipher key and expands all 11 round keys into an internal buffer, one round per cycle. It then serves the keys in reverse order (round 10 down to round 0) over a valid/ready stream. Each served key feeds the inverse add-round-key XOR stage in the same row-word format the encryption datapath uses.

---
 rtl/aes_pkg.sv | 20 ++
 rtl/aes_sbox.sv | 45 ++++
 rtl/aes_inv_key_sched.sv | 125 ++++++++++++
 tb/tb_aes_inv_key_sched.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions for the key scheduler and the encryption datapath.
package aes_pkg;

  localparam int NR = 10;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE,
    EXPAND,
    SERVE
  } state_t;

  // Round constants indexed by round number; entry 0 and 11..15 are unused.
  localparam logic [7:0] RCON [16] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

endpackage

// File: rtl/aes_sbox.sv
// Combinational forward AES S-box: GF(2^8) inverse followed by the affine map.
module aes_sbox (
  input  logic [7:0] x,
  output logic [7:0] y
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] s;
    p = 8'h00;
    s = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ s;
      s = {s[6:0], 1'b0} ^ (s[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse, and maps 0 to 0 as the S-box needs.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] s;
    r = 8'h01;
    s = a;
    for (int i = 1; i < 8; i++) begin
      s = gf_mul(s, s);
      r = gf_mul(r, s);
    end
    return r;
  endfunction

  logic [7:0] inv;

  // Inverse then affine transform with constant 0x63.
  always_comb begin
    inv = gf_inv(x);
    y   = inv
        ^ {inv[6:0], inv[7]}
        ^ {inv[5:0], inv[7:6]}
        ^ {inv[4:0], inv[7:5]}
        ^ {inv[3:0], inv[7:4]}
        ^ 8'h63;
  end

endmodule

// File: rtl/aes_inv_key_sched.sv
// AES-128 key expansion into an 11-entry buffer, then round keys streamed
// out in reverse order (10 down to 0) over a valid/ready interface.
//
// state  | meaning
// IDLE   | waiting for a cipher key, key_ready high
// EXPAND | computing round cnt per cycle into the buffer
// SERVE  | presenting buffer[rk_idx] until the round-0 handshake
module aes_inv_key_sched
  import aes_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_valid,
  output logic        key_ready,
  input  logic [31:0] key0,
  input  logic [31:0] key1,
  input  logic [31:0] key2,
  input  logic [31:0] key3,
  output logic        rk_valid,
  input  logic        rk_ready,
  output logic [31:0] rk0,
  output logic [31:0] rk1,
  output logic [31:0] rk2,
  output logic [31:0] rk3,
  output logic [3:0]  rk_idx,
  output logic        rk_last,
  output logic        busy
);

  state_t       state;
  logic [3:0]   cnt;
  word_t        w [4];
  logic [127:0] buffer [NR+1];

  word_t        rot;
  word_t        sub;
  word_t        t;
  word_t        n0, n1, n2, n3;
  logic [3:0]   rd_idx;
  logic         accept;

  for (genvar i = 0; i < 4; i++) begin : g_sbox
    aes_sbox u_sbox (
      .x(rot[8*i +: 8]),
      .y(sub[8*i +: 8])
    );
  end

  // Next round's words from the current working words.
  always_comb begin
    rot    = {w[3][7:0], w[3][31:8]};
    t      = sub ^ {24'h0, RCON[cnt]};
    n0     = w[0] ^ t;
    n1     = w[1] ^ n0;
    n2     = w[2] ^ n1;
    n3     = w[3] ^ n2;
    rd_idx = rk_idx - 4'd1;
    accept = (state == IDLE) && key_valid && key_ready;
  end

  // Round-key storage; contents after a reset are don't-care so no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      buffer[0] <= {key3, key2, key1, key0};
    end else if (state == EXPAND) begin
      buffer[cnt] <= {n3, n2, n1, n0};
    end
  end

  // Sequencer with all handshake and round-key outputs registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      w         <= '{default: '0};
      key_ready <= 1'b1;
      busy      <= 1'b0;
      rk_valid  <= 1'b0;
      rk_last   <= 1'b0;
      rk_idx    <= 4'd0;
      {rk3, rk2, rk1, rk0} <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            w         <= '{key0, key1, key2, key3};
            cnt       <= 4'd1;
            state     <= EXPAND;
            key_ready <= 1'b0;
            busy      <= 1'b1;
          end
        end
        EXPAND: begin
          w   <= '{n0, n1, n2, n3};
          cnt <= cnt + 4'd1;
          if (cnt == 4'(NR)) begin
            state    <= SERVE;
            rk_valid <= 1'b1;
            rk_idx   <= 4'(NR);
            rk_last  <= 1'b0;
            {rk3, rk2, rk1, rk0} <= {n3, n2, n1, n0};
          end
        end
        SERVE: begin
          if (rk_ready) begin
            if (rk_idx == 4'd0) begin
              state     <= IDLE;
              rk_valid  <= 1'b0;
              rk_last   <= 1'b0;
              key_ready <= 1'b1;
              busy      <= 1'b0;
              {rk3, rk2, rk1, rk0} <= '0;
            end else begin
              rk_idx  <= rd_idx;
              rk_last <= (rk_idx == 4'd1);
              {rk3, rk2, rk1, rk0} <= buffer[rd_idx];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_inv_key_sched.sv
// Self-checking bench: randomized keys and back-pressure against a
// byte-level FIPS-197 key expansion model.
module tb_aes_inv_key_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        key_valid = 1'b0;
  logic        key_ready;
  logic [31:0] key0 = '0, key1 = '0, key2 = '0, key3 = '0;
  logic        rk_valid;
  logic        rk_ready = 1'b0;
  logic [31:0] rk0, rk1, rk2, rk3;
  logic [3:0]  rk_idx;
  logic        rk_last;
  logic        busy;

  int checks = 0;
  int failures = 0;

  logic [7:0]   sbox_t [256];
  logic [127:0] exp_rk [11];
  logic [127:0] dut_rk;

  assign dut_rk = {rk3, rk2, rk1, rk0};

  aes_inv_key_sched dut (
    .clk(clk), .rst_n(rst_n),
    .key_valid(key_valid), .key_ready(key_ready),
    .key0(key0), .key1(key1), .key2(key2), .key3(key3),
    .rk_valid(rk_valid), .rk_ready(rk_ready),
    .rk0(rk0), .rk1(rk1), .rk2(rk2), .rk3(rk3),
    .rk_idx(rk_idx), .rk_last(rk_last), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
    logic [15:0] d;
    d = {b, b} << k;
    return d[15:8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // S-box table by walking the generator 3 and its inverse in lockstep.
  task automatic build_sbox();
    logic [7:0] p;
    logic [7:0] q;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ xtime(p);
      q = q ^ (q << 1);
      q = q ^ (q << 2);
      q = q ^ (q << 4);
      if (q[7]) q = q ^ 8'h09;
      sbox_t[p] = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4) ^ 8'h63;
    end while (p != 8'h01);
    sbox_t[0] = 8'h63;
  endtask

  // FIPS-197 word expansion; byte 0 of each word in bits [7:0].
  task automatic model(input logic [127:0] key);
    logic [31:0] wk [44];
    logic [31:0] tmp;
    logic [7:0]  b [4];
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) wk[i] = key[32*i +: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = wk[i-1];
      if (i % 4 == 0) begin
        for (int j = 0; j < 4; j++) b[j] = tmp[8*((j+1)%4) +: 8];
        b[0] = sbox_t[b[0]] ^ rc;
        b[1] = sbox_t[b[1]];
        b[2] = sbox_t[b[2]];
        b[3] = sbox_t[b[3]];
        tmp = {b[3], b[2], b[1], b[0]};
        rc = xtime(rc);
      end
      wk[i] = wk[i-4] ^ tmp;
    end
    for (int r = 0; r < 11; r++)
      exp_rk[r] = {wk[4*r+3], wk[4*r+2], wk[4*r+1], wk[4*r]};
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_key_ready"}, key_ready, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_rk_valid"}, rk_valid, 0);
    check({tag, "_rk_last"}, rk_last, 0);
    check({tag, "_rk_idx"}, rk_idx, 0);
    check({tag, "_rk_words"}, dut_rk, 0);
  endtask

  task automatic start_key(input logic [127:0] k, output int waits);
    logic rdy;
    {key3, key2, key1, key0} = k;
    key_valid = 1'b1;
    waits = 0;
    while (1) begin
      rdy = key_ready;
      @(negedge clk);
      if (rdy) break;
      waits++;
      if (waits > 50) begin
        check("accept_timeout", 0, 1);
        break;
      end
    end
    key_valid = 1'b0;
  endtask

  task automatic wait_expand(input bit junk);
    int cycles;
    cycles = 0;
    while (!rk_valid && cycles < 40) begin
      check("expand_key_ready", key_ready, 0);
      check("expand_busy", busy, 1);
      if (junk) begin
        key_valid = 1'($urandom_range(0, 1));
        {key3, key2, key1, key0} = {$urandom, $urandom, $urandom, $urandom};
      end
      @(negedge clk);
      cycles++;
    end
    key_valid = 1'b0;
    check("latency", cycles, 10);
  endtask

  task automatic serve(input bit bp, input bit fips, input int abort_at,
                       input bit b2b, input logic [127:0] nk);
    int  e;
    int  cyc;
    bit  rdy;
    e = 10;
    cyc = 0;
    while (e >= 0 && cyc < 300) begin
      check("rk_valid", rk_valid, 1);
      check("rk_idx", rk_idx, e);
      check($sformatf("rk_round%0d", e), dut_rk, exp_rk[e]);
      check("rk_last", rk_last, e == 0);
      check("serve_key_ready", key_ready, 0);
      check("serve_busy", busy, 1);
      if (fips && e == 10)
        check("fips_r10", dut_rk, {32'hc5302b4d, 32'h8ba707f3, 32'h174a94e3, 32'h7f1d1113});
      if (fips && e == 1)
        check("fips_r1", dut_rk, {32'hfe76abd6, 32'hf178a6da, 32'hfa72afd2, 32'hfd74aad6});
      if (fips && e == 0)
        check("fips_r0", dut_rk, {32'h0f0e0d0c, 32'h0b0a0908, 32'h07060504, 32'h03020100});
      if (e == abort_at) begin
        rst_n = 1'b0;
        rk_ready = 1'b0;
        key_valid = 1'b0;
        @(negedge clk);
        check_reset("serve_abort");
        rst_n = 1'b1;
        return;
      end
      rdy = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      rk_ready = rdy;
      if (e > 0) begin
        key_valid = bp ? 1'($urandom_range(0, 1)) : 1'b0;
        if (key_valid) {key3, key2, key1, key0} = {$urandom, $urandom, $urandom, $urandom};
      end else if (b2b) begin
        key_valid = 1'b1;
        {key3, key2, key1, key0} = nk;
      end else begin
        key_valid = 1'b0;
      end
      @(negedge clk);
      cyc++;
      if (rdy) e--;
    end
    rk_ready = 1'b0;
    if (!b2b) key_valid = 1'b0;
    if (cyc >= 300) check("serve_timeout", 0, 1);
    check_reset("serve_done");
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin
    logic [127:0] k;
    logic [127:0] k2;
    int waits;

    build_sbox();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset("idle");

    // FIPS-197 key, no back-pressure
    k = {32'h0f0e0d0c, 32'h0b0a0908, 32'h07060504, 32'h03020100};
    model(k);
    start_key(k, waits);
    wait_expand(1'b0);
    serve(1'b0, 1'b1, -1, 1'b0, '0);

    // Random keys with back-pressure and ignored key_valid pulses
    for (int n = 0; n < 4; n++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      model(k);
      start_key(k, waits);
      wait_expand(1'b1);
      serve(1'b1, 1'b0, -1, 1'b0, '0);
    end

    // Reset while EXPAND is at cnt=5, then a fresh key
    k = {$urandom, $urandom, $urandom, $urandom};
    model(k);
    start_key(k, waits);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset("expand_abort");
    rst_n = 1'b1;
    k = {$urandom, $urandom, $urandom, $urandom};
    model(k);
    start_key(k, waits);
    check("post_abort_accept", waits, 0);
    wait_expand(1'b0);
    serve(1'b0, 1'b0, -1, 1'b0, '0);

    // Reset while serving rk_idx=6, then a fresh key
    k = {$urandom, $urandom, $urandom, $urandom};
    model(k);
    start_key(k, waits);
    wait_expand(1'b0);
    serve(1'b0, 1'b0, 6, 1'b0, '0);
    k = {$urandom, $urandom, $urandom, $urandom};
    model(k);
    start_key(k, waits);
    wait_expand(1'b0);
    serve(1'b1, 1'b0, -1, 1'b0, '0);

    // Back-to-back: next key presented on the round-0 handshake
    k  = {$urandom, $urandom, $urandom, $urandom};
    k2 = {$urandom, $urandom, $urandom, $urandom};
    model(k);
    start_key(k, waits);
    wait_expand(1'b0);
    serve(1'b0, 1'b0, -1, 1'b1, k2);
    model(k2);
    start_key(k2, waits);
    check("b2b_accept_wait", waits, 0);
    wait_expand(1'b0);
    serve(1'b0, 1'b0, -1, 1'b0, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
